// File: rtl/load_store_pkg.sv
// Shared types and defaults for the load/store volume scheduler.
package load_store_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

  localparam logic DIR_FILL  = 1'b1;
  localparam logic DIR_DRAIN = 1'b0;

  localparam int DEF_CAP   = 7500;
  localparam int DEF_CBITS = 13;

endpackage

// File: rtl/ls_rr_arb.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module ls_rr_arb #(
  parameter int NREQ  = 4,
  parameter int PBITS = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [PBITS-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PBITS-1:0] idx,
  output logic             any
);

  logic [NREQ-1:0] elig;
  int              pos;

  always_comb begin
    elig = req & mask;
    any  = |elig;
    gnt  = '0;
    idx  = '0;
    pos  = 0;
    // Scan from farthest to nearest so the closest eligible slot past ptr wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NREQ;
      if (elig[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = PBITS'(pos);
      end
    end
  end

endmodule

// File: rtl/load_store_sched.sv
// Shared load/store volume scheduler: round-robin grants, one unit per cycle.
// Optional macro LOAD_STORE_SCHED_DRAIN_PRIO_EN favours drains when full and fills when empty.
module load_store_sched
  import load_store_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CAP   = DEF_CAP,
  parameter int CBITS = DEF_CBITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       dir,
  input  logic [NREQ*CBITS-1:0] amt,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic                  sat,
  output logic                  abort,
  output logic [CBITS-1:0]      vol,
  output logic                  full,
  output logic                  empty
);

  localparam int              PBITS = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] CAP_V = CBITS'(CAP);

  state_t             state, state_nx;
  logic [PBITS-1:0]   ptr, ptr_nx, win, win_nx;
  logic               cur_dir, cur_dir_nx;
  logic [CBITS-1:0]   remaining, rem_nx, vol_nx;
  logic               sat_q, sat_nx, abort_nx;

  logic [NREQ-1:0]    arb_mask, arb_gnt;
  logic [PBITS-1:0]   arb_idx;
  logic               arb_any;

`ifdef LOAD_STORE_SCHED_DRAIN_PRIO_EN
  // Drain requesters have dir low, fill requesters dir high.
  always_comb begin
    arb_mask = '1;
    if (full && |(req & ~dir))
      arb_mask = ~dir;
    else if (empty && |(req & dir))
      arb_mask = dir;
  end
`else
  assign arb_mask = '1;
`endif

  ls_rr_arb #(.NREQ(NREQ), .PBITS(PBITS)) u_arb (
    .req  (req),
    .mask (arb_mask),
    .ptr  (ptr),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      cur_dir   <= DIR_DRAIN;
      remaining <= '0;
      vol       <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      sat_q     <= 1'b0;
      abort     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state     <= state_nx;
      ptr       <= ptr_nx;
      win       <= win_nx;
      cur_dir   <= cur_dir_nx;
      remaining <= rem_nx;
      vol       <= vol_nx;
      full      <= (vol_nx == CAP_V);
      empty     <= (vol_nx == '0);
      sat_q     <= sat_nx;
      abort     <= abort_nx;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_nx   = state;
    ptr_nx     = ptr;
    win_nx     = win;
    cur_dir_nx = cur_dir;
    rem_nx     = remaining;
    vol_nx     = vol;
    sat_nx     = 1'b0;
    abort_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          win_nx     = arb_idx;
          cur_dir_nx = |(arb_gnt & dir);
          rem_nx     = amt[arb_idx*CBITS +: CBITS];
          state_nx   = GRANT;
        end
      end
      GRANT: state_nx = RUN;
      RUN: begin
        if (!req[win]) begin
          abort_nx = 1'b1;
          state_nx = IDLE;
        end else if (remaining == '0) begin
          state_nx = DONE;
        end else if (cur_dir == DIR_FILL) begin
          if (vol == CAP_V) begin
            sat_nx   = 1'b1;
            state_nx = DONE;
          end else begin
            vol_nx = vol + 1'b1;
            rem_nx = remaining - 1'b1;
          end
        end else begin
          if (vol == '0) begin
            sat_nx   = 1'b1;
            state_nx = DONE;
          end else begin
            vol_nx = vol - 1'b1;
            rem_nx = remaining - 1'b1;
          end
        end
      end
      DONE: begin
        ptr_nx   = (win == PBITS'(NREQ - 1)) ? '0 : win + 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state != IDLE)
      gnt[win] = 1'b1;
    done = (state == DONE);
    sat  = done & sat_q;
  end

endmodule
